bus_arbiter_mux: RTL
====================

# bus_arbiter_mux

Parametrised, registered successor to the 8:1 bus multiplexer: arbitrates between `CHANNELS` bus sources by request/grant handshake and drives the winner's data onto the shared internal data bus through an output register. Default round-robin arbitration; a lock input lets a multi-cycle transfer (e.g. ALU result writeback or memory burst) hold the bus. Sits between the register file / ALU / memory-data sources and the CPU's single internal data bus.

## Interface
- `WIDTH`, 8, data width of every source and of `out`
- `CHANNELS`, 8, number of sources; legal range 2..16
- `SEL_W`, `$clog2(CHANNELS)`, width of `sel`; derived, never overridden
- `clk`  input  1  system clock; all state updates on rising edge
- `rst`  input  1  reset; synchronous and active-high
- `req`  input  CHANNELS  per-source bus request, level-sensitive
- `in_flat`  input  CHANNELS*WIDTH  source data; channel k at bits [k*WIDTH +: WIDTH]
- `lock`  input  1  hold current grant even if its `req` drops
- `grant`  output  CHANNELS  one-hot registered grant; all-zero when idle
- `grant_valid`  output  1  high when any grant bit is set
- `sel`  output  SEL_W  index of granted channel; holds last value when idle
- `out`  output  WIDTH  registered bus data
- `out_valid`  output  1  `out` holds data of a granted channel

## Operation
- Two states: IDLE (no grant) and OWNED (one channel granted).
- Arbitration (round-robin): search starts at `ptr`, ascending, wrapping CHANNELS-1 -> 0; first set `req` bit wins. After each grant, `ptr` = winner+1 mod CHANNELS.
- IDLE -> OWNED: any `req` bit set; winner registered into `grant`/`sel`.
- OWNED stays: `req[sel]` high, or `lock` high.
- OWNED release (`req[sel]` low and `lock` low): if other requests pending, re-arbitrate on the same edge and hand over directly (no idle cycle); otherwise -> IDLE, `grant`=0.
- The releasing channel is never re-granted on the handoff edge unless it is the only requester (it cannot be, since its `req` is low).
- `lock` in IDLE has no effect. `lock` never causes a grant.
- Data path: every edge, `out` <= slice of `in_flat` selected by the current (pre-edge) `sel`, and `out_valid` <= `grant_valid`. When `grant_valid` is low, `out` <= 0.
- Requests from the granted channel may change data each cycle; `out` follows with one cycle of delay.
- `req` bits at index >= CHANNELS do not exist; no out-of-range `sel` can be produced.

## Timing
- Reset (rst high at edge): `grant`=0, `grant_valid`=0, `sel`=0, `out`=0, `out_valid`=0, `ptr`=0 (channel 0 highest priority first). Reset mid-transfer aborts ownership immediately; `lock` ignored.
- Latency: `req` high before edge E -> `grant`/`sel` valid after E -> `out`/`out_valid` valid after E+1 (2 cycles request-to-data).
- Release: `req[sel]` low before edge E -> new `grant` (or zero) after E; `out_valid` drops / switches source after E+1.
- Simultaneous requests: exactly one grant; others wait, no starvation — each waiting channel is granted within CHANNELS-1 ownership periods.
- `grant` is one-hot or zero on every cycle; `sel` and `grant` always agree while `grant_valid`.

## Configuration
- `BUS_ARB_FIXED_PRIO_EN`: when defined, arbitration is fixed priority — lowest requesting index wins, `ptr` is removed. When undefined, round-robin as above. All other behaviour (lock, handoff, latency, reset) identical in both builds.

## Test plan
- Reset: CHANNELS=8, WIDTH=8, `in_k`=1<<k, assert `rst` 2 cycles with `req`=8'hFF -> `grant`=0, `out`=0, `out_valid`=0; first grant after release of `rst` goes to channel 0.
- Single source: `req`=8'h08 -> cycle+1 `grant`=8'h08, `sel`=3; cycle+2 `out`=8'h08, `out_valid`=1; drop `req` -> `grant`=0, then `out_valid`=0.
- Round-robin sweep: `req`=8'hFF, each owner drops `req` for one cycle after one owned cycle -> grant order 0,1,...,7,0 with no idle cycles; `out` sequence 01,02,04,...,80. With `BUS_ARB_FIXED_PRIO_EN`, same stimulus -> channel 0 re-wins whenever it requests.
- Lock: channel 2 owns, `lock`=1, `req[2]`=0, `req[5]`=1 for 4 cycles -> `grant` stays 8'h04; drop `lock` -> next edge `grant`=8'h20, following edge `out`=8'h20.
- Data tracking: channel 6 owns, change `in_6` 8'h40 -> 8'hA5 -> `out`=8'hA5 exactly one cycle later.
- Reset mid-transfer: channel 4 owns with `lock`=1, pulse `rst` -> all outputs zero next edge; after release with `req`=8'h30 -> `grant`=8'h10 (ptr reset to 0).

Source files
------------

// File: rtl/bus_arbiter_mux.sv
// Registered request/grant bus arbiter with output data mux; round-robin by default,
// fixed priority (lowest index wins) when BUS_ARB_FIXED_PRIO_EN is defined.
module bus_arbiter_mux #(
    parameter int unsigned WIDTH    = 8,
    parameter int unsigned CHANNELS = 8,
    parameter int unsigned SEL_W    = $clog2(CHANNELS)
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [CHANNELS-1:0]          req,
    input  logic [CHANNELS*WIDTH-1:0]    in_flat,
    input  logic                         lock,
    output logic [CHANNELS-1:0]          grant,
    output logic                         grant_valid,
    output logic [SEL_W-1:0]             sel,
    output logic [WIDTH-1:0]             out,
    output logic                         out_valid
);

    localparam int unsigned IDX_W = SEL_W + 1;

    typedef enum logic {
        IDLE  = 1'b0,
        OWNED = 1'b1
    } state_e;

    state_e               state_q, state_d;
    logic [CHANNELS-1:0]  grant_q, grant_d;
    logic                 grant_valid_q, grant_valid_d;
    logic [SEL_W-1:0]     sel_q, sel_d;
    logic [WIDTH-1:0]     out_q, out_d;
    logic                 out_valid_q, out_valid_d;

    logic [SEL_W-1:0]     arb_base;
    logic [SEL_W-1:0]     arb_idx;
    logic                 arb_found;
    logic [IDX_W-1:0]     cand;
    logic [WIDTH-1:0]     in_arr [CHANNELS];

`ifdef BUS_ARB_FIXED_PRIO_EN
    assign arb_base = '0;
`else
    logic [SEL_W-1:0]     ptr_q, ptr_d;
    assign arb_base = ptr_q;
`endif

    for (genvar k = 0; k < CHANNELS; k++) begin : g_unpack
        assign in_arr[k] = in_flat[k*WIDTH +: WIDTH];
    end

    // First requester at or after arb_base, wrapping past CHANNELS-1
    always_comb begin
        arb_found = 1'b0;
        arb_idx   = '0;
        cand      = '0;
        for (int unsigned i = 0; i < CHANNELS; i++) begin
            cand = IDX_W'(arb_base) + IDX_W'(i);
            if (cand >= IDX_W'(CHANNELS)) begin
                cand = cand - IDX_W'(CHANNELS);
            end
            if (!arb_found && req[cand[SEL_W-1:0]]) begin
                arb_found = 1'b1;
                arb_idx   = cand[SEL_W-1:0];
            end
        end
    end

    // Ownership FSM; a release re-arbitrates on the same edge so handoff has no idle cycle
    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        sel_d   = sel_q;
`ifndef BUS_ARB_FIXED_PRIO_EN
        ptr_d   = ptr_q;
`endif
        case (state_q)
            IDLE: begin
                if (arb_found) begin
                    state_d = OWNED;
                end
            end
            OWNED: begin
                if (!req[sel_q] && !lock) begin
                    state_d = arb_found ? OWNED : IDLE;
                    if (!arb_found) begin
                        grant_d = '0;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        if (arb_found && (state_q == IDLE || (!req[sel_q] && !lock))) begin
            grant_d = CHANNELS'(1) << arb_idx;
            sel_d   = arb_idx;
`ifndef BUS_ARB_FIXED_PRIO_EN
            ptr_d   = (IDX_W'(arb_idx) == IDX_W'(CHANNELS - 1)) ? '0 : SEL_W'(arb_idx + SEL_W'(1));
`endif
        end

        grant_valid_d = (state_d == OWNED);
        out_valid_d   = grant_valid_q;
        out_d         = grant_valid_q ? in_arr[sel_q] : '0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= IDLE;
            grant_q       <= '0;
            grant_valid_q <= 1'b0;
            sel_q         <= '0;
            out_q         <= '0;
            out_valid_q   <= 1'b0;
`ifndef BUS_ARB_FIXED_PRIO_EN
            ptr_q         <= '0;
`endif
        end else begin
            state_q       <= state_d;
            grant_q       <= grant_d;
            grant_valid_q <= grant_valid_d;
            sel_q         <= sel_d;
            out_q         <= out_d;
            out_valid_q   <= out_valid_d;
`ifndef BUS_ARB_FIXED_PRIO_EN
            ptr_q         <= ptr_d;
`endif
        end
    end

    assign grant       = grant_q;
    assign grant_valid = grant_valid_q;
    assign sel         = sel_q;
    assign out         = out_q;
    assign out_valid   = out_valid_q;

endmodule
